crc_stream_arbiter: RTL and testbench
=====================================

# crc_stream_arbiter

Packet-level round-robin arbiter that shares one `crc_checker_axi` instance between `NUM_SRC` AXI-Stream sources. It sits directly upstream of the checker's `s_axis` port. Each source sends a frame whose final beat carries the CRC word. The arbiter locks a grant for a whole frame (first beat through `tlast`) so frames never interleave. It tags each forwarded frame with its source ID for downstream error attribution.

## Interface
- `DATA_WIDTH`, 32, stream data width; matches the checker.
- `NUM_SRC`, 4, number of requesting sources (2..16).
- `SRC_W`, `$clog2(NUM_SRC)` (minimum 1), width of the source-ID fields.

- `axis_aclk`  in  1  single clock for all logic.
- `axis_areset`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  `NUM_SRC*DATA_WIDTH`  flattened source data; source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid`  in  `NUM_SRC`  per-source valid.
- `s_axis_tlast`  in  `NUM_SRC`  per-source last (CRC beat).
- `s_axis_tready`  out  `NUM_SRC`  per-source ready.
- `m_axis_tdata`  out  `DATA_WIDTH`  data to the checker.
- `m_axis_tvalid`  out  1  valid to the checker.
- `m_axis_tlast`  out  1  last to the checker.
- `m_axis_tready`  in  1  ready from the checker.
- `m_axis_tid`  out  `SRC_W`  ID of the granted source; stable for the whole frame.
- `busy`  out  1  high while a grant is held.
- `pkt_done`  out  1  one-cycle pulse after the `tlast` handshake.
- `pkt_src`  out  `SRC_W`  source of the completed frame; valid with `pkt_done`.

## Operation
- State machine with two states, IDLE and LOCK.
  - Registers: `grant` (`SRC_W`) and `last_grant` (`SRC_W`).
- IDLE:
  - Nothing is forwarded. `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, all `s_axis_tready`=0.
  - If any `s_axis_tvalid` bit is set, select the first requester at or after `last_grant+1` (mod `NUM_SRC`), load it into `grant`, and go to LOCK.
- LOCK (granted source g):
  - `m_axis_tdata`/`tvalid`/`tlast` are a combinational pass-through of source g.
  - `s_axis_tready[g]` = `m_axis_tready`; every other ready bit is 0.
  - `m_axis_tid` = g.
- Frame end is the handshake `m_axis_tvalid & m_axis_tready & m_axis_tlast`. On that edge:
  - `last_grant` ← g; `pkt_done` ← 1; `pkt_src` ← g.
  - Re-arbitrate in the same cycle. Search starts at g+1 and sees the requests present in that cycle; source g itself is eligible only after all others.
  - Any request found: load the new grant and stay in LOCK, giving zero-bubble frame-to-frame hand-over. Otherwise go to IDLE.
- Granted source deasserts `tvalid` mid-frame: the grant is held and `m_axis_tvalid` follows the source. There is no timeout.
- Non-granted sources see ready=0 and must hold their data (AXI rule).
- Single-beat frame (`tlast` on the first beat) is legal and completes in one handshake cycle.
- No data is registered; the datapath adds no storage.

## Timing
- Reset (`axis_areset`=1 at a clock edge):
  - State → IDLE, `grant`=0, `last_grant`=`NUM_SRC-1`, so source 0 has first priority.
  - Outputs after reset: `busy`=0, `pkt_done`=0, `pkt_src`=0, `m_axis_tid`=0, all data/valid/last/ready outputs 0.
  - Reset mid-frame abandons the frame immediately; no `pkt_done` is generated.
- Latency from IDLE: a request at edge N is granted (LOCK, `busy`=1) after edge N. The first beat can therefore be accepted in the cycle following edge N.
- Latency through LOCK: combinational, 0 cycles from source to `m_axis`.
- `pkt_done` is registered. It is high in the cycle after the `tlast` handshake, for exactly 1 cycle.
- `busy` = (state==LOCK), registered.
- Back-to-back frames run with no idle cycle between frames of different sources.
- Simultaneous requests from all sources are served strictly in rotation 0,1,2,3,0,…

## Structure
- Package `crc_axi_pkg`:
  - `DATA_WIDTH` default constant.
  - `arb_state_t` enum {IDLE, LOCK}.
  - `src_id_t` typedef sized by `NUM_SRC`.
- Sub-module `rr_pick`: combinational, parameterised by `NUM_SRC`. Inputs are the request vector and `last_grant`; outputs are `found` and `idx`. It is reused in both the IDLE and frame-end paths.
- Top level holds the FSM, grant registers and output muxing. Estimated size is about 150–200 lines.

## Test plan
- Single source: source 0 sends 5,3,678,76,89,0x06b9a027 (`tlast` on the final beat), `m_axis_tready`=1.
  - Grant at cycle 1; six beats appear unchanged on `m_axis` with `m_axis_tid`=0.
  - `pkt_done`=1 with `pkt_src`=0 one cycle after the last beat; `busy` drops.
- Contention: sources 1 and 2 raise valid in the same cycle with 3-beat frames.
  - Source 1 is served first, then source 2 with no bubble between frames.
  - Source 2 `s_axis_tready` stays 0 throughout source 1's frame.
- Rotation: all 4 sources continuously hold 2-beat frames.
  - Grant order is 0,1,2,3,0,1; exactly 8 handshakes per full rotation.
- Backpressure and gaps: `m_axis_tready` toggles 1,0,1,0 and the source drops `tvalid` for 2 cycles mid-frame.
  - No beat is lost or duplicated; grant is held; a higher-priority source that becomes valid meanwhile gets ready=0.
- Reset mid-frame: assert `axis_areset` for 1 cycle during beat 3 of source 2.
  - All outputs are 0 the next cycle, no `pkt_done`.
  - A subsequent request from source 0 and source 2 together grants source 0 first.

Source files
------------

// File: rtl/crc_axi_pkg.sv
// Shared types and defaults for the CRC checker stream front-end.
// Arbiter state encoding and source-ID type live here so every block agrees on them.
package crc_axi_pkg;

   localparam int DATA_WIDTH  = 32;
   localparam int NUM_SRC_DEF = 4;
   localparam int SRC_W_DEF   = (NUM_SRC_DEF > 1) ? $clog2(NUM_SRC_DEF) : 1;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_t;

   typedef logic [SRC_W_DEF-1:0] src_id_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first requester at or after last_grant+1, wrapping modulo NUM_SRC.
// Purely combinational; the caller decides which base and request mask to present.
module rr_pick
   import crc_axi_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [SRC_W-1:0]   last_grant,
   output logic               found,
   output logic [SRC_W-1:0]   idx
);

   logic [SRC_W-1:0] cand;

   // Walk from the farthest candidate back to the nearest so the nearest one wins.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand = SRC_W'((int'(last_grant) + k) % NUM_SRC);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/crc_stream_arbiter.sv
// Frame-locked round-robin arbiter feeding one crc_checker_axi from NUM_SRC stream sources.
// The datapath is a pure mux; only the grant, rotation pointer and completion pulse are stored.
module crc_stream_arbiter
   import crc_axi_pkg::*;
#(
   parameter int DATA_WIDTH = crc_axi_pkg::DATA_WIDTH,
   parameter int NUM_SRC    = 4,
   parameter int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                          axis_aclk,
   input  logic                          axis_areset,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [NUM_SRC-1:0]            s_axis_tvalid,
   input  logic [NUM_SRC-1:0]            s_axis_tlast,
   output logic [NUM_SRC-1:0]            s_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [SRC_W-1:0]              m_axis_tid,
   output logic                          busy,
   output logic                          pkt_done,
   output logic [SRC_W-1:0]              pkt_src
);

   arb_state_t       state_q, state_d;
   logic [SRC_W-1:0] grant_q, grant_d;
   logic [SRC_W-1:0] last_grant_q, last_grant_d;
   logic [SRC_W-1:0] pkt_src_q, pkt_src_d;
   logic             pkt_done_q, pkt_done_d;

   logic               lock;
   logic               frame_end;
   logic [NUM_SRC-1:0] pick_req;
   logic [SRC_W-1:0]   pick_base;
   logic               pick_found;
   logic [SRC_W-1:0]   pick_idx;

   assign lock       = (state_q == LOCK);
   assign busy       = lock;
   assign pkt_done   = pkt_done_q;
   assign pkt_src    = pkt_src_q;
   assign m_axis_tid = lock ? grant_q : '0;

   // NOTE: every output gets a default before the branch, so no path infers a latch.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      if (lock) begin
         m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
         m_axis_tvalid          = s_axis_tvalid[grant_q];
         m_axis_tlast           = s_axis_tlast[grant_q];
         s_axis_tready[grant_q] = m_axis_tready;
      end
   end

   assign frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // At frame end the granted source's valid belongs to the beat just taken, not a new request.
   always_comb begin
      pick_req  = s_axis_tvalid;
      pick_base = last_grant_q;
      if (lock) begin
         pick_req[grant_q] = 1'b0;
         pick_base         = grant_q;
      end
   end

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SRC_W   (SRC_W)
   ) u_pick (
      .req        (pick_req),
      .last_grant (pick_base),
      .found      (pick_found),
      .idx        (pick_idx)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      pkt_src_d    = pkt_src_q;
      pkt_done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = LOCK;
               grant_d = pick_idx;
            end
         end
         LOCK: begin
            if (frame_end) begin
               pkt_done_d   = 1'b1;
               pkt_src_d    = grant_q;
               last_grant_d = grant_q;
               if (pick_found) grant_d = pick_idx;
               else            state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers are updated with <= only, so all flops sample the same pre-edge values.
   always_ff @(posedge axis_aclk) begin
      if (axis_areset) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         last_grant_q <= SRC_W'(NUM_SRC - 1);
         pkt_done_q   <= 1'b0;
         pkt_src_q    <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         pkt_done_q   <= pkt_done_d;
         pkt_src_q    <= pkt_src_d;
      end
   end

endmodule

// File: tb/tb_crc_stream_arbiter.sv
// Self-checking bench for crc_stream_arbiter: vector table, directed corner sequences,
// and randomized traffic compared cycle by cycle against a frame-level reference model.
module tb_crc_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [DW-1:0]   data [N];
   logic [N-1:0]    valid, last;
   logic            mready;
   logic [N*DW-1:0] s_tdata;
   logic [N-1:0]    s_tready;
   logic [DW-1:0]   m_tdata;
   logic            m_tvalid, m_tlast, busy, pkt_done;
   logic [SW-1:0]   m_tid, pkt_src;

   assign s_tdata = {data[3], data[2], data[1], data[0]};

   crc_stream_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(N), .SRC_W(SW)) dut (
      .axis_aclk     (clk),
      .axis_areset   (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tvalid (valid),
      .s_axis_tlast  (last),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (mready),
      .m_axis_tid    (m_tid),
      .busy          (busy),
      .pkt_done      (pkt_done),
      .pkt_src       (pkt_src)
   );

   typedef struct {
      logic [31:0] d;
      bit          l;
   } beat_t;

   typedef struct {
      bit          v, l, r;
      logic [31:0] d;
      bit          ev, el, eb, edone, erdy;
      logic [31:0] ed;
   } vec_t;

   beat_t srcq [N][$];
   bit    hold [N];

   // Reference model: frame-level view of who owns the output and the rotation pointer.
   bit m_lock, m_done;
   int m_g, m_last, m_src;

   int          hs_src [$];
   logic [31:0] hs_data [$];
   int          hs_cyc [$];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(input logic [N-1:0] req, input int from, input int count);
      for (int k = 0; k < count; k++) begin
         if (req[(from + k) % N]) return (from + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_lock = 0; m_g = 0; m_last = N - 1; m_done = 0; m_src = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (srcq[i].size() > 0 && !hold[i]) begin
            valid[i] = 1'b1; data[i] = srcq[i][0].d; last[i] = srcq[i][0].l;
         end else begin
            valid[i] = 1'b0; data[i] = '0; last[i] = 1'b0;
         end
      end
   endtask

   task automatic push_frame(input int src, input int len, input logic [31:0] base);
      for (int b = 0; b < len; b++) srcq[src].push_back('{base + b, (b == len - 1)});
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += srcq[i].size();
      return s;
   endfunction

   task automatic clear_log();
      hs_src.delete(); hs_data.delete(); hs_cyc.delete();
   endtask

   // One clock: compare all outputs with the model, then advance the model across the edge.
   task automatic step();
      logic          ev, el;
      logic [31:0]   ed;
      logic [N-1:0]  er;
      bit            hs;
      int            p;
      #1;
      ev = m_lock ? valid[m_g] : 1'b0;
      el = m_lock ? last[m_g]  : 1'b0;
      ed = m_lock ? data[m_g]  : '0;
      er = '0;
      if (m_lock) er[m_g] = mready;
      check("m_tvalid", m_tvalid, ev);
      check("m_tlast",  m_tlast,  el);
      check("m_tdata",  m_tdata,  ed);
      check("s_tready", s_tready, er);
      check("m_tid",    m_tid,    m_lock ? m_g : 0);
      check("busy",     busy,     m_lock);
      check("pkt_done", pkt_done, m_done);
      check("pkt_src",  pkt_src,  m_src);
      if (!rst && m_tvalid && mready) begin
         hs_src.push_back(int'(m_tid)); hs_data.push_back(m_tdata); hs_cyc.push_back(cyc);
      end
      hs = m_lock && valid[m_g] && mready;
      @(posedge clk);
      m_done = 0;
      if (rst) begin
         model_reset();
      end else if (!m_lock) begin
         p = pick(valid, m_last + 1, N);
         if (p >= 0) begin m_lock = 1; m_g = p; end
      end else if (hs) begin
         if (srcq[m_g].size() > 0) void'(srcq[m_g].pop_front());
         if (last[m_g]) begin
            m_done = 1; m_src = m_g; m_last = m_g;
            p = pick(valid, m_g + 1, N - 1);
            if (p >= 0) m_g = p;
            else        m_lock = 0;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic drain(input int budget);
      int c = 0;
      while (pending() > 0 && c < budget) begin
         drive(); step(); c++;
      end
      check("drain_left", pending(), 0);
      repeat (2) begin drive(); step(); end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) begin hold[i] = 0; srcq[i].delete(); end
      drive(); step();
      rst = 1'b0;
      clear_log();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   vec_t tbl [9];
   int   leak;

   initial begin
      rst = 1'b1; mready = 1'b0; valid = '0; last = '0;
      for (int i = 0; i < N; i++) begin data[i] = '0; hold[i] = 0; end
      repeat (2) @(posedge clk);
      @(negedge clk);
      model_reset();
      do_reset();

      // Single source frame 5,3,678,76,89,CRC with ready held high.
      tbl[0] = '{v:1, l:0, r:1, d:5,            ev:0, el:0, eb:0, edone:0, erdy:0, ed:0};
      tbl[1] = '{v:1, l:0, r:1, d:5,            ev:1, el:0, eb:1, edone:0, erdy:1, ed:5};
      tbl[2] = '{v:1, l:0, r:1, d:3,            ev:1, el:0, eb:1, edone:0, erdy:1, ed:3};
      tbl[3] = '{v:1, l:0, r:1, d:678,          ev:1, el:0, eb:1, edone:0, erdy:1, ed:678};
      tbl[4] = '{v:1, l:0, r:1, d:76,           ev:1, el:0, eb:1, edone:0, erdy:1, ed:76};
      tbl[5] = '{v:1, l:0, r:1, d:89,           ev:1, el:0, eb:1, edone:0, erdy:1, ed:89};
      tbl[6] = '{v:1, l:1, r:1, d:32'h06b9a027, ev:1, el:1, eb:1, edone:0, erdy:1, ed:32'h06b9a027};
      tbl[7] = '{v:0, l:0, r:1, d:0,            ev:0, el:0, eb:0, edone:1, erdy:0, ed:0};
      tbl[8] = '{v:0, l:0, r:1, d:0,            ev:0, el:0, eb:0, edone:0, erdy:0, ed:0};
      for (int t = 0; t < 9; t++) begin
         valid = {3'b000, tbl[t].v}; last = {3'b000, tbl[t].l}; data[0] = tbl[t].d;
         mready = tbl[t].r;
         #1;
         check("tbl_tvalid", m_tvalid,    tbl[t].ev);
         check("tbl_tlast",  m_tlast,     tbl[t].el);
         check("tbl_tdata",  m_tdata,     tbl[t].ed);
         check("tbl_busy",   busy,        tbl[t].eb);
         check("tbl_done",   pkt_done,    tbl[t].edone);
         check("tbl_ready0", s_tready[0], tbl[t].erdy);
         if (tbl[t].eb) check("tbl_tid", m_tid, 0);
         if (tbl[t].edone) check("tbl_pkt_src", pkt_src, 0);
         step();
      end
      data[0] = '0;

      // Contention: sources 1 and 2 request together with 3-beat frames.
      clear_log();
      push_frame(1, 3, 32'h110); push_frame(2, 3, 32'h220);
      leak = 0;
      for (int c = 0; c < 20 && pending() > 0; c++) begin
         drive(); #1;
         if (hs_src.size() < 3 && s_tready[2]) leak++;
         step();
      end
      check("cont_src2_ready_leak", leak, 0);
      check("cont_count", hs_src.size(), 6);
      if (hs_src.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            check("cont_src",  hs_src[k],  (k < 3) ? 1 : 2);
            check("cont_data", hs_data[k], (k < 3) ? 32'h110 + k : 32'h220 + k - 3);
         end
         check("cont_no_bubble", hs_cyc[3] - hs_cyc[2], 1);
      end
      drain(10);

      // Rotation: every source holds two 2-beat frames.
      do_reset();
      for (int i = 0; i < N; i++) begin
         push_frame(i, 2, 32'h1000 * i);
         push_frame(i, 2, 32'h1000 * i + 32'h10);
      end
      drain(60);
      check("rot_count", hs_src.size(), 16);
      if (hs_src.size() == 16) begin
         for (int k = 0; k < 16; k++) check("rot_order", hs_src[k], (k / 2) % N);
         check("rot_no_bubble", hs_cyc[15] - hs_cyc[0], 15);
      end

      // Backpressure and source gaps, with a higher-priority source arriving mid-frame.
      do_reset();
      push_frame(1, 4, 32'hB1);
      for (int c = 0; c < 30 && pending() > 0; c++) begin
         mready  = (c % 2 == 0);
         hold[1] = (c == 3 || c == 4);
         if (c == 2) push_frame(0, 1, 32'hA0);
         drive(); #1;
         if (c >= 2 && c <= 6) check("bp_hi_prio_ready", s_tready[0], 1'b0);
         if (c == 3) check("bp_grant_held", busy, 1'b1);
         step();
      end
      hold[1] = 0; mready = 1'b1;
      drain(10);
      check("bp_count", hs_src.size(), 5);
      if (hs_src.size() == 5) begin
         for (int k = 0; k < 5; k++) begin
            check("bp_src",  hs_src[k],  (k < 4) ? 1 : 0);
            check("bp_data", hs_data[k], (k < 4) ? 32'hB1 + k : 32'hA0);
         end
      end

      // Reset during beat 3 of source 2, then sources 0 and 2 request together.
      do_reset();
      mready = 1'b1;
      push_frame(2, 5, 32'hC1);
      for (int c = 0; c < 10 && hs_src.size() < 2; c++) begin drive(); step(); end
      check("rst_beats_before", hs_src.size(), 2);
      rst = 1'b1; drive(); step(); rst = 1'b0;
      srcq[2].delete(); drive(); #1;
      check("rst_tvalid", m_tvalid, 1'b0);
      check("rst_tdata",  m_tdata,  '0);
      check("rst_tready", s_tready, '0);
      check("rst_busy",   busy,     1'b0);
      check("rst_done",   pkt_done, 1'b0);
      check("rst_tid",    m_tid,    '0);
      step();
      clear_log();
      push_frame(0, 2, 32'hD0); push_frame(2, 2, 32'hE0);
      drain(20);
      check("rst_after_count", hs_src.size(), 4);
      if (hs_src.size() == 4) begin
         check("rst_first_src",  hs_src[0], 0);
         check("rst_second_src", hs_src[2], 2);
      end

      // Randomized traffic against the reference model.
      do_reset();
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < N; i++) begin
            if (srcq[i].size() < 8 && $urandom_range(0, 5) == 0)
               push_frame(i, $urandom_range(1, 4), $urandom);
            hold[i] = ($urandom_range(0, 7) == 0);
         end
         mready = ($urandom_range(0, 3) != 0);
         drive(); step();
      end
      for (int i = 0; i < N; i++) hold[i] = 0;
      mready = 1'b1;
      drain(400);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
